alu_writeback: RTL and testbench
================================

# alu_writeback

Writeback stage directly downstream of the 8-bit accumulator ALU. It accepts one ALU result per cycle over a valid/ready handshake, commits it to the architectural accumulator, updates the N/Z/C/V status register per opcode, and queues register-file writes in a 2-entry buffer drained over a second valid/ready port. The accumulator and flags it holds feed back to the ALU `acc_in` and to branch resolution.

## Interface
Parameters:
- WIDTH, 8, datapath width
- NREG, 8, register-file entries; RA = $clog2(NREG)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  execute-stage result valid
- ex_ready  out  1  stage can accept
- ex_optype  in  1  ALU optype; 1 = non-ALU, consumed as no-op
- ex_op  in  4  ALU opcode
- ex_result  in  WIDTH  ALU OUT
- ex_z, ex_c, ex_n, ex_v  in  1 each  ALU flags
- ex_dst  in  1  0 = accumulator, 1 = register file
- ex_rd  in  RA  register-file destination
- rf_wr_valid  out  1  register write pending
- rf_wr_ready  in  1  register file accepts write
- rf_wr_addr  out  RA  write address
- rf_wr_data  out  WIDTH  write data
- rf_pending  out  1  buffer non-empty (decode interlock)
- acc  out  WIDTH  accumulator
- flags  out  4  {n, z, c, v}
- cond  in  3  branch condition code
- cond_true  out  1  condition satisfied by current flags
- retired  out  16  count of accepted transactions

## Operation
- Accept = ex_valid && ex_ready. ex_ready = (count < 2); forced 0 while rst_n low. It does not depend on rf_wr_ready (no push-through-pop when full).
- Opcode classes apply only when ex_optype = 0:
  - 0010 add, 0011 sub: write result; z = (ex_result == 0), n = ex_result[WIDTH-1], c = ex_c, v = ex_v.
  - 0100–1001 (shl, shr, and, or, xor, popcnt): write result; z and n from ex_result; c and v unchanged.
  - 1010 compare: no write; z = ex_z, n = ex_n; c and v unchanged.
  - Any other opcode: no write, no flag change.
- ex_optype = 1: accepted, counted in retired, no state change.
- Write target: ex_dst = 0 loads acc at the accept edge. ex_dst = 1 pushes {ex_rd, ex_result} into the FIFO; acc is unchanged.
- FIFO: 2 entries, in-order, registered storage.
  - rf_wr_valid = (count != 0); addr and data come from the head.
  - Pop on rf_wr_valid && rf_wr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - rf_pending = rf_wr_valid.
- cond_true is combinational from the flags register:
  - 000 always, 001 z, 010 !z, 011 n, 100 !n, 101 c, 110 !c, 111 never.
- retired increments by 1 per accept and wraps 0xFFFF -> 0x0000.

## Timing
- Reset (async assert, synchronous-to-clk release): acc = 0, flags = 0000, count = 0, rf_wr_valid = 0, retired = 0, FIFO pointers = 0. Contents are don't-care.
- Reset mid-operation drops buffered writes immediately; rf_wr_valid falls asynchronously.
- acc and flags reflect an accepted transaction on the cycle after the accept edge. Back-to-back accepts each see the prior commit, giving the ALU zero-bubble accumulator forwarding.
- Register write: rf_wr_valid is asserted at the earliest the cycle after accept (latency 1). Sustained throughput is 1 per cycle while rf_wr_ready = 1.
- Full: count = 2 drops ex_ready. It reasserts the cycle after the first pop.
- Empty with rf_wr_ready high: no spurious pop; count never underflows.
- rf_wr_addr and rf_wr_data are stable while rf_wr_valid && !rf_wr_ready.
- Accumulator-destination ops are also blocked while the buffer is full. This is deliberate and keeps completion strictly in order.

## Test plan
- Reset, then add with ex_result = 0x00, ex_c = 1, dst = acc -> next cycle acc = 0x00, flags = {n0, z1, c1, v0}, cond 001 -> cond_true = 1.
- Compare with ex_z = 0, ex_n = 1 after flags c = 1 -> acc unchanged, flags = {1, 0, 1, v}, cond 011 = 1, cond 101 = 1.
- Three back-to-back dst = rf writes (r1 = 0x11, r2 = 0x22, r3 = 0x33) with rf_wr_ready = 0 -> ex_ready low after the second accept. Raise rf_wr_ready -> writes appear in order 1/0x11, 2/0x22, then the third is accepted and appears as 3/0x33.
- Continuous writes with rf_wr_ready = 1 -> count stays at or below 1 and one write per cycle; rf_pending = 1 throughout.
- Assert rst_n low with 2 entries buffered and acc = 0x5A -> rf_wr_valid, acc, flags and retired are all 0 immediately; no write is issued after release.
- 65536 optype = 1 accepts -> retired wraps to 0x0000; acc and flags are untouched.

Source files
------------

// File: rtl/alu_writeback.sv
// Writeback stage for the 8-bit accumulator ALU: commits results to the accumulator,
// updates N/Z/C/V, and buffers register-file writes in a 2-entry in-order FIFO.
module alu_writeback #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 8,
    localparam int unsigned RA   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic             ex_optype,
    input  logic [3:0]       ex_op,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             ex_z,
    input  logic             ex_c,
    input  logic             ex_n,
    input  logic             ex_v,
    input  logic             ex_dst,
    input  logic [RA-1:0]    ex_rd,
    output logic             rf_wr_valid,
    input  logic             rf_wr_ready,
    output logic [RA-1:0]    rf_wr_addr,
    output logic [WIDTH-1:0] rf_wr_data,
    output logic             rf_pending,
    output logic [WIDTH-1:0] acc,
    output logic [3:0]       flags,
    input  logic [2:0]       cond,
    output logic             cond_true,
    output logic [15:0]      retired
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       flags_q, flags_d;
    logic [15:0]      retired_q;
    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, rd_ptr_q;
    logic [RA-1:0]    fifo_addr_q [2];
    logic [WIDTH-1:0] fifo_data_q [2];

    logic accept, is_alu, is_arith, is_logic, is_cmp, writes, push, pop;
    logic res_z, res_n;

    // ex_ready gated by rst_n so nothing is accepted while reset is held
    assign ex_ready = rst_n && (count_q < 2'd2);
    assign accept   = ex_valid && ex_ready;
    assign is_alu   = !ex_optype;
    assign is_arith = (ex_op == 4'b0010) || (ex_op == 4'b0011);
    assign is_logic = (ex_op >= 4'b0100) && (ex_op <= 4'b1001);
    assign is_cmp   = (ex_op == 4'b1010);
    assign writes   = is_alu && (is_arith || is_logic);
    assign push     = accept && writes && ex_dst;
    assign pop      = rf_wr_valid && rf_wr_ready;
    assign res_z    = (ex_result == '0);
    assign res_n    = ex_result[WIDTH-1];

    always_comb begin
        acc_d   = acc_q;
        flags_d = flags_q;
        if (accept && is_alu) begin
            if (writes && !ex_dst) acc_d = ex_result;
            if (is_arith) begin
                flags_d = {res_n, res_z, ex_c, ex_v};
            end else if (is_logic) begin
                flags_d = {res_n, res_z, flags_q[1:0]};
            end else if (is_cmp) begin
                flags_d = {ex_n, ex_z, flags_q[1:0]};
            end
        end
    end

    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            flags_q   <= '0;
            retired_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
            count_q <= count_d;
            if (accept) retired_q <= retired_q + 16'd1;
            if (push)   wr_ptr_q  <= ~wr_ptr_q;
            if (pop)    rd_ptr_q  <= ~rd_ptr_q;
        end
    end

    // Storage contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= ex_rd;
            fifo_data_q[wr_ptr_q] <= ex_result;
        end
    end

    assign rf_wr_valid = (count_q != 2'd0);
    assign rf_pending  = rf_wr_valid;
    assign rf_wr_addr  = fifo_addr_q[rd_ptr_q];
    assign rf_wr_data  = fifo_data_q[rd_ptr_q];
    assign acc         = acc_q;
    assign flags       = flags_q;
    assign retired     = retired_q;

    // flags = {n, z, c, v}
    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            3'b000: cond_true = 1'b1;
            3'b001: cond_true = flags_q[2];
            3'b010: cond_true = !flags_q[2];
            3'b011: cond_true = flags_q[3];
            3'b100: cond_true = !flags_q[3];
            3'b101: cond_true = flags_q[1];
            3'b110: cond_true = !flags_q[1];
            3'b111: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_optype, ex_z, ex_c, ex_n, ex_v, ex_dst;
    logic [3:0]  ex_op;
    logic [7:0]  ex_result;
    logic [2:0]  ex_rd;
    logic        rf_wr_valid, rf_wr_ready, rf_pending, cond_true;
    logic [2:0]  rf_wr_addr, cond;
    logic [7:0]  rf_wr_data, acc;
    logic [3:0]  flags;
    logic [15:0] retired;

    alu_writeback #(.WIDTH(8), .NREG(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_optype(ex_optype), .ex_op(ex_op),
        .ex_result(ex_result), .ex_z(ex_z), .ex_c(ex_c), .ex_n(ex_n), .ex_v(ex_v),
        .ex_dst(ex_dst), .ex_rd(ex_rd),
        .rf_wr_valid(rf_wr_valid), .rf_wr_ready(rf_wr_ready), .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data), .rf_pending(rf_pending),
        .acc(acc), .flags(flags), .cond(cond), .cond_true(cond_true), .retired(retired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0]  m_acc;
    logic [3:0]  m_flags;   // {n, z, c, v}
    logic [15:0] m_ret;
    logic [10:0] m_q[$];    // {addr, data}
    bit          last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_cond(input logic [2:0] c, input logic [3:0] f);
        case (c)
            3'd0: return 1'b1;
            3'd1: return f[2];
            3'd2: return !f[2];
            3'd3: return f[3];
            3'd4: return !f[3];
            3'd5: return f[1];
            3'd6: return !f[1];
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_acc = 8'h00; m_flags = 4'h0; m_ret = 16'h0; m_q.delete();
    endtask

    task automatic apply_txn();
        int op;
        m_ret = m_ret + 16'd1;
        if (ex_optype) return;
        op = int'(ex_op);
        if (op == 2 || op == 3)
            m_flags = {ex_result[7], ex_result == 8'h00, ex_c, ex_v};
        else if (op >= 4 && op <= 9)
            m_flags = {ex_result[7], ex_result == 8'h00, m_flags[1:0]};
        else if (op == 10)
            m_flags = {ex_n, ex_z, m_flags[1:0]};
        if (op >= 2 && op <= 9) begin
            if (ex_dst) m_q.push_back({ex_rd, ex_result});
            else        m_acc = ex_result;
        end
    endtask

    task automatic check_outputs();
        logic [10:0] head;
        chk("ex_ready", 32'(ex_ready), 32'(m_q.size() < 2));
        chk("rf_wr_valid", 32'(rf_wr_valid), 32'(m_q.size() != 0));
        chk("rf_pending", 32'(rf_pending), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            head = m_q[0];
            chk("rf_wr_addr", 32'(rf_wr_addr), 32'(head[10:8]));
            chk("rf_wr_data", 32'(rf_wr_data), 32'(head[7:0]));
        end
        chk("acc", 32'(acc), 32'(m_acc));
        chk("flags", 32'(flags), 32'(m_flags));
        chk("retired", 32'(retired), 32'(m_ret));
        chk("cond_true", 32'(cond_true), 32'(exp_cond(cond, m_flags)));
    endtask

    // One clock: check at negedge, then advance the model across the posedge
    task automatic cycle();
        bit acc_now, pop_now;
        @(negedge clk);
        check_outputs();
        acc_now = ex_valid && (m_q.size() < 2);
        pop_now = (m_q.size() != 0) && rf_wr_ready;
        @(posedge clk);
        if (pop_now) void'(m_q.pop_front());
        if (acc_now) apply_txn();
        last_acc = acc_now;
        #1;
    endtask

    task automatic drive(input logic v, input logic ot, input logic [3:0] op,
                         input logic [7:0] res, input logic dst, input logic [2:0] rd);
        ex_valid = v; ex_optype = ot; ex_op = op; ex_result = res; ex_dst = dst; ex_rd = rd;
    endtask

    initial begin
        rst_n = 1'b0; drive(0, 0, 4'h0, 8'h00, 0, 3'd0);
        ex_z = 0; ex_c = 0; ex_n = 0; ex_v = 0; rf_wr_ready = 0; cond = 3'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        cycle();

        // Add with zero result, carry set -> {n0, z1, c1, v0}
        drive(1, 0, 4'b0010, 8'h00, 0, 3'd0); ex_c = 1; cond = 3'b001;
        cycle();
        ex_valid = 0; ex_c = 0;
        cycle();
        chk("add_flags", 32'(flags), 32'(4'b0110));
        chk("add_cond_z", 32'(cond_true), 32'(1'b1));

        // Compare: z/n from ALU, c kept
        drive(1, 0, 4'b1010, 8'h77, 0, 3'd0); ex_z = 0; ex_n = 1; cond = 3'b011;
        cycle();
        ex_valid = 0;
        cycle();
        chk("cmp_flags", 32'(flags), 32'(4'b1010));
        chk("cmp_acc", 32'(acc), 32'(8'h00));
        chk("cmp_cond_n", 32'(cond_true), 32'(1'b1));
        cond = 3'b101; #1;
        chk("cmp_cond_c", 32'(cond_true), 32'(1'b1));
        ex_n = 0;

        // Three rf writes against a stalled register file
        rf_wr_ready = 0;
        drive(1, 0, 4'b0110, 8'h11, 1, 3'd1); cycle();
        drive(1, 0, 4'b0110, 8'h22, 1, 3'd2); cycle();
        drive(1, 0, 4'b0110, 8'h33, 1, 3'd3);
        chk("full_ready", 32'(ex_ready), 32'(1'b0));
        cycle();
        chk("held_head_addr", 32'(rf_wr_addr), 32'(3'd1));
        chk("held_head_data", 32'(rf_wr_data), 32'(8'h11));
        rf_wr_ready = 1;
        last_acc = 0;
        for (int i = 0; i < 6 && !last_acc; i++) cycle();
        chk("third_accepted", 32'(last_acc), 32'(1'b1));
        ex_valid = 0;
        repeat (3) cycle();

        // Streaming writes with the register file always ready
        rf_wr_ready = 1;
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 4'b0111, 8'(i * 7 + 1), 1, 3'(i));
            cycle();
            chk("stream_pending", 32'(rf_pending), 32'(1'b1));
            chk("stream_ready", 32'(ex_ready), 32'(1'b1));
        end
        ex_valid = 0;
        repeat (2) cycle();

        // Mid-operation reset with acc = 0x5A and two writes buffered
        drive(1, 0, 4'b0100, 8'h5A, 0, 3'd0); cycle();
        rf_wr_ready = 0;
        drive(1, 0, 4'b1000, 8'hC3, 1, 3'd4); cycle();
        drive(1, 0, 4'b1000, 8'h3C, 1, 3'd5); cycle();
        ex_valid = 0;
        chk("pre_rst_acc", 32'(acc), 32'(8'h5A));
        #2 rst_n = 1'b0; #1;
        chk("rst_wr_valid", 32'(rf_wr_valid), 32'(1'b0));
        chk("rst_acc", 32'(acc), 32'(8'h00));
        chk("rst_flags", 32'(flags), 32'(4'h0));
        chk("rst_retired", 32'(retired), 32'(16'h0));
        chk("rst_ready", 32'(ex_ready), 32'(1'b0));
        model_reset();
        rf_wr_ready = 1;
        @(negedge clk); rst_n = 1'b1; #1;
        repeat (2) cycle();

        // Retired counter wrap with optype = 1 traffic
        drive(1, 0, 4'b0101, 8'hA5, 0, 3'd0); cycle();
        drive(1, 1, 4'b0010, 8'hFF, 0, 3'd0);
        repeat (65535) @(posedge clk);
        #1;
        ex_valid = 0;
        m_ret = m_ret + 16'd65535;
        chk("wrap_retired", 32'(retired), 32'(16'h0000));
        chk("wrap_acc", 32'(acc), 32'(8'hA5));
        cycle();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom), 3'($urandom));
            ex_z = 1'($urandom); ex_c = 1'($urandom); ex_n = 1'($urandom); ex_v = 1'($urandom);
            rf_wr_ready = 1'($urandom_range(0, 2) != 0);
            cond = 3'($urandom);
            cycle();
        end
        ex_valid = 0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
